frame_painter: RTL

- Drawing engine on the write side of frame_buffer; the other end of the buffer from the pixel_iterator scan-out reader.
- Each frame, clears the back buffer, then rasterises a stream of filled 1-bit rectangles into it through the frame_buffer write port.
- After the last rectangle it waits for the swap pulse from pixel_iterator, then starts the next frame.
- Game logic feeds rectangles (bird, pipes, ground) over a valid/ready handshake.

---
 rtl/frame_painter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/frame_painter.sv
// rtl/frame_painter.sv - frame buffer writer: clears the back buffer, then rasterises
// filled 1-bit rectangles and waits for the buffer swap before the next frame.
module frame_painter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk_rgb,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  swap,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_WIDTH-1:0]    cmd_x0,
    input  logic [Y_WIDTH-1:0]    cmd_y0,
    input  logic [X_WIDTH:0]      cmd_x1,
    input  logic [Y_WIDTH:0]      cmd_y1,
    input  logic                  cmd_color,
    input  logic                  cmd_last,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_data,
    output logic                  frame_done,
    output logic [7:0]            dropped_swaps
);

    localparam int NPIX_M1 = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS - 1;
    localparam logic [X_WIDTH:0]      W_X       = HOR_ACTIVE_PIXELS[X_WIDTH:0];
    localparam logic [Y_WIDTH:0]      H_Y       = VER_ACTIVE_PIXELS[Y_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] W_A       = HOR_ACTIVE_PIXELS[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = NPIX_M1[ADDR_WIDTH-1:0];

    typedef enum logic [1:0] {CLEAR, CMD, DRAW, WAIT_SWAP} state_t;

    // Start-of-rectangle row base as a shift-and-add over the set bits of the width.
    function automatic logic [ADDR_WIDTH-1:0] row_offset(input logic [Y_WIDTH-1:0] y);
        logic [ADDR_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (HOR_ACTIVE_PIXELS[i]) acc = acc + (ADDR_WIDTH'(y) << i);
        end
        return acc;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [X_WIDTH-1:0]    x_q, x_d, x0_q, x0_d;
    logic [Y_WIDTH-1:0]    y_q, y_d;
    logic [X_WIDTH:0]      x1c_q, x1c_d;
    logic [Y_WIDTH:0]      y1c_q, y1c_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                  color_q, color_d, last_q, last_d;
    logic                  wr_en_q, wr_en_d, wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  cmd_ready_q, cmd_ready_d, frame_done_q, frame_done_d;
    logic [7:0]            dropped_q, dropped_d;

    logic [X_WIDTH:0]      x1c, lim_x, px_inc;
    logic [Y_WIDTH:0]      y1c, lim_y, py_inc;
    logic [X_WIDTH-1:0]    pos_x, start_x;
    logic [Y_WIDTH-1:0]    pos_y;
    logic [ADDR_WIDTH-1:0] pos_base;
    logic                  in_cmd, hs, empty, row_end, rect_end, draw_step, fin_last, pix_color;

    always_comb begin
        x1c       = (cmd_x1 > W_X) ? W_X : cmd_x1;
        y1c       = (cmd_y1 > H_Y) ? H_Y : cmd_y1;
        empty     = ({1'b0, cmd_x0} >= x1c) || ({1'b0, cmd_y0} >= y1c);
        hs        = ce && cmd_valid && cmd_ready_q;
        in_cmd    = (state_q == CMD);
        // The accepting edge draws the first pixel straight from the command fields.
        pos_x     = in_cmd ? cmd_x0 : x_q;
        pos_y     = in_cmd ? cmd_y0 : y_q;
        pos_base  = in_cmd ? row_offset(cmd_y0) : row_base_q;
        start_x   = in_cmd ? cmd_x0 : x0_q;
        lim_x     = in_cmd ? x1c : x1c_q;
        lim_y     = in_cmd ? y1c : y1c_q;
        fin_last  = in_cmd ? cmd_last : last_q;
        pix_color = in_cmd ? cmd_color : color_q;
        px_inc    = {1'b0, pos_x} + {{X_WIDTH{1'b0}}, 1'b1};
        py_inc    = {1'b0, pos_y} + {{Y_WIDTH{1'b0}}, 1'b1};
        row_end   = (px_inc == lim_x);
        rect_end  = row_end && (py_inc == lim_y);
        draw_step = (in_cmd && hs && !empty) || (state_q == DRAW);

        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        x_d          = x_q;
        x0_d         = x0_q;
        y_d          = y_q;
        x1c_d        = x1c_q;
        y1c_d        = y1c_q;
        row_base_d   = row_base_q;
        color_d      = color_q;
        last_d       = last_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_ready_d  = cmd_ready_q;
        frame_done_d = frame_done_q;
        dropped_d    = dropped_q;

        if (ce) begin
            wr_en_d = 1'b0;
            if (swap && state_q != WAIT_SWAP && dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
            case (state_q)
                CLEAR: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_addr_q;
                    wr_data_d = 1'b0;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d     = CMD;
                        cmd_ready_d = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                CMD: begin
                    if (hs && empty && cmd_last) begin
                        state_d      = WAIT_SWAP;
                        cmd_ready_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end
                    if (hs && !empty) begin
                        x0_d    = cmd_x0;
                        x1c_d   = x1c;
                        y1c_d   = y1c;
                        color_d = cmd_color;
                        last_d  = cmd_last;
                    end
                end
                WAIT_SWAP: begin
                    if (swap) begin
                        state_d      = CLEAR;
                        clr_addr_d   = '0;
                        frame_done_d = 1'b0;
                    end
                end
                default: ;
            endcase

            if (draw_step) begin
                wr_en_d   = 1'b1;
                wr_addr_d = pos_base + ADDR_WIDTH'(pos_x);
                wr_data_d = pix_color;
                if (rect_end) begin
                    if (fin_last) begin
                        state_d      = WAIT_SWAP;
                        cmd_ready_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d     = CMD;
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    state_d     = DRAW;
                    cmd_ready_d = 1'b0;
                    if (row_end) begin
                        x_d        = start_x;
                        y_d        = py_inc[Y_WIDTH-1:0];
                        row_base_d = pos_base + W_A;
                    end else begin
                        x_d        = px_inc[X_WIDTH-1:0];
                        y_d        = pos_y;
                        row_base_d = pos_base;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            x_q          <= '0;
            x0_q         <= '0;
            y_q          <= '0;
            x1c_q        <= '0;
            y1c_q        <= '0;
            row_base_q   <= '0;
            color_q      <= 1'b0;
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            x_q          <= x_d;
            x0_q         <= x0_d;
            y_q          <= y_d;
            x1c_q        <= x1c_d;
            y1c_q        <= y1c_d;
            row_base_q   <= row_base_d;
            color_q      <= color_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cmd_ready_q  <= cmd_ready_d;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
        end
    end

    // A held write or ready is only presented in cycles where the buffer side is enabled.
    assign wr_en         = wr_en_q && ce;
    assign cmd_ready     = cmd_ready_q && ce;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign frame_done    = frame_done_q;
    assign dropped_swaps = dropped_q;

endmodule
